// File: rtl/key_pkg.sv
// ============================================================================
// Module   : key_pkg
// Brief    : Shared types and level constants for pushbutton conditioning.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        KEY_REL        = 2'd0,
        KEY_PRESS_WAIT = 2'd1,
        KEY_PRESSED    = 2'd2,
        KEY_REL_WAIT   = 2'd3
    } key_state_t;

    // KEY pins are active-low
    localparam logic KEY_PRESSED_LVL  = 1'b0;
    localparam logic KEY_RELEASED_LVL = 1'b1;

endpackage : key_pkg

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module   : sync_ff
// Brief    : Generic flop-chain synchroniser with synchronous preset/clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_ff

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronises and debounces one active-low pushbutton; flags
//            aborted level changes as a one-cycle glitch pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key_raw,
    output logic key_clean,
    output logic stable,
    output logic glitch
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_synced;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clean;
    logic             w_clean_nxt;
    logic             r_glitch;
    logic             w_glitch_nxt;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (KEY_RELEASED_LVL)
    ) u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .i_d   (key_raw),
        .o_q   (w_synced)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= KEY_REL;
            r_cnt    <= '0;
            r_clean  <= KEY_RELEASED_LVL;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clean  <= w_clean_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    // Counter saturates at the acceptance value: acceptance leaves the WAIT
    // state on the same edge, so no increment past c_cnt_last is needed.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_clean_nxt  = r_clean;
        w_glitch_nxt = 1'b0;
        case (r_state)
            KEY_REL: begin
                if (w_synced == KEY_PRESSED_LVL) begin
                    w_state_nxt = KEY_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (w_synced != KEY_PRESSED_LVL) begin
                    w_state_nxt  = KEY_REL;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = KEY_PRESSED;
                    w_clean_nxt = KEY_PRESSED_LVL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            KEY_PRESSED: begin
                if (w_synced != KEY_PRESSED_LVL) begin
                    w_state_nxt = KEY_REL_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            KEY_REL_WAIT: begin
                if (w_synced == KEY_PRESSED_LVL) begin
                    w_state_nxt  = KEY_PRESSED;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = KEY_REL;
                    w_clean_nxt = KEY_RELEASED_LVL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = KEY_REL;
                w_clean_nxt = KEY_RELEASED_LVL;
            end
        endcase
    end

    always_comb begin
        stable    = (r_state == KEY_REL) || (r_state == KEY_PRESSED);
        key_clean = r_clean;
        glitch    = r_glitch;
    end

endmodule : key_debounce

`default_nettype wire
